sudoku_mem_sequencer: RTL
=========================

// Module: sudoku_mem_sequencer
// PURPOSE
//  Owns the single-port game RAM (4 x 16b rows) and the puzzle ROM (16 x 20b words, 4 puzzles x 4 rows).
//  Sequences puzzle load (ROM -> RAM) at reset and on request, keeps the write-protect map and the initial config.
//  Arbitrates RAM access between requester A (interface controller: read/write) and requester B (checker: read-only).
//  Enforces write protection in hardware: protected nibbles always keep their ROM value.
// PARAMETERS
//  ROWS   4   game rows; RAM depth; rows per puzzle in ROM
//  NIB    4   nibbles per row; write-protect bits per ROM word
// PORTS
//  CLK        in   1   system clock, all state on posedge
//  RST_N      in   1   asynchronous, active-low reset
//  loadReq    in   1   start load of puzzle puzzleSel; sampled in SERVE only
//  puzzleSel  in   2   puzzle index; latched when loadReq is accepted
//  loadBusy   out  1   high in LOAD_RD/LOAD_WR
//  loadDone   out  1   one-cycle pulse on the first SERVE cycle after a load
//  wpMask     out  16  write-protect map; bit 4r+i = row r, nibble i
//  aReq       in   1   A access request; held until aGnt
//  aWe        in   1   A write (1) / read (0)
//  aAddr      in   2   A row
//  aWdat      in   16  A write data (full row)
//  aGnt       out  1   A granted this cycle (combinational)
//  aRdat      out  16  read data (RamDat pass-through)
//  aRvalid    out  1   aRdat valid; cycle after a granted A read
//  bReq       in   1   B read request; held until bGnt
//  bAddr      in   2   B row
//  bGnt       out  1   B granted this cycle (combinational)
//  bRdat      out  16  read data (RamDat pass-through)
//  bRvalid    out  1   bRdat valid; cycle after a granted B read
//  RomAddr    out  4   ROM address = {puzzle, row}; 1-cycle read latency
//  RomDat     in   20  [19:16] write-protect (bit i -> nibble i), [15:0] row digits
//  RamAddr    out  2   RAM address
//  RamWriteBit out 1   RAM write enable
//  RamWdat    out  16  RAM write data
//  RamDat     in   16  RAM read data; 1-cycle read latency
// BEHAVIOUR
//  States: LOAD_RD, LOAD_WR, SERVE. Reset: state=LOAD_RD, row=0, puzzle=0, wpMask=0, initCfg(64b)=0,
//   lastGnt=B, aRvalid=bRvalid=0, loadDone=0. Outputs derived from state give loadBusy=1, grants=0, RamWriteBit=0.
//  LOAD_RD: RomAddr={puzzle,row}; no RAM write -> LOAD_WR.
//  LOAD_WR: RomAddr held; RamAddr=row, RamWriteBit=1, RamWdat=RomDat[15:0];
//   wpMask[4row+3:4row] <= RomDat[19:16]; initCfg row <= RomDat[15:0].
//   row==3 -> SERVE with loadDone=1 next cycle, row<=0; else row++ and -> LOAD_RD.
//   Full load = 8 cycles. loadReq and requests are ignored; grants=0.
//  SERVE, loadReq=1: accept; puzzle<=puzzleSel; no grant this cycle; -> LOAD_RD.
//   loadReq has priority over both requesters.
//  SERVE, no loadReq: at most one grant per cycle, round-robin.
//   Only one requester -> it wins. Both -> the requester not in lastGnt wins; lastGnt <= winner.
//  Grant cycle: RamAddr=winner addr. Grant is combinational; winner drops req or issues next access.
//  A write grant: RamWriteBit=1, RamWdat=(aWdat & ~M) | (initCfg[aAddr] & M).
//   M = wpMask row aAddr with each bit expanded to a nibble. No rvalid is generated.
//  Read grant: winner's rvalid=1 next cycle; RamDat holds that row then. rvalid also fires if the
//   grant cycle accepted... never: no grant occurs on a loadReq cycle.
//  Idle SERVE: RamAddr=0, RamWriteBit=0.
//  RST_N low in any state: async return to reset values, then reload puzzle 0 from row 0.
// TESTING
//  T1 ROM puzzle0 rows r0..r3=20'hF1234,2'h0..., release RST_N: RomAddr 0,0,1,1,2,2,3,3; RAM rows match;
//     wpMask[3:0]=F; loadDone pulses at cycle 9.
//  T2 row1 ROM 20'h4_1234 (nibble2 protected), A writes 16'hABCD to row1 -> RamWdat=16'hA2CD; read-back A2CD.
//  T3 aReq & bReq held high 6 cycles, both reads -> grants A,B,A,B,A,B;
//     each rvalid 1 cycle after its grant with correct row data.
//  T4 SERVE, bReq=1 and loadReq=1 with puzzleSel=2 same cycle -> bGnt=0; RomAddr 8..11;
//     bGnt returns on the loadDone cycle.
//  T5 RST_N low during LOAD_WR row2 -> RamWriteBit=0 and wpMask=0 immediately;
//     after release, load restarts at RomAddr 0.
//  T6 loadReq held high during LOAD -> ignored; exactly one load runs; grant only after loadDone.

Source files
------------

// File: rtl/sudoku_mem_sequencer.sv
// Game RAM / puzzle ROM sequencer: loads a 4-row puzzle from ROM into RAM, keeps the write-protect
// map and the initial digits, and arbitrates RAM access round-robin between requesters A and B.
module sudoku_mem_sequencer #(
  parameter int ROWS = 4,
  parameter int NIB  = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        loadReq,
  input  logic [1:0]  puzzleSel,
  output logic        loadBusy,
  output logic        loadDone,
  output logic [15:0] wpMask,
  input  logic        aReq,
  input  logic        aWe,
  input  logic [1:0]  aAddr,
  input  logic [15:0] aWdat,
  output logic        aGnt,
  output logic [15:0] aRdat,
  output logic        aRvalid,
  input  logic        bReq,
  input  logic [1:0]  bAddr,
  output logic        bGnt,
  output logic [15:0] bRdat,
  output logic        bRvalid,
  output logic [3:0]  RomAddr,
  input  logic [19:0] RomDat,
  output logic [1:0]  RamAddr,
  output logic        RamWriteBit,
  output logic [15:0] RamWdat,
  input  logic [15:0] RamDat,
  output logic [1:0]  stateDbg
);

  localparam int RW = NIB * 4;
  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  typedef enum logic [1:0] {
    LOAD_RD = 2'd0,
    LOAD_WR = 2'd1,
    SERVE   = 2'd2
  } state_t;

  // Handshake: a requester holds req (with its addr/we/wdat) until the cycle its gnt is high;
  // gnt is combinational in that cycle, and a granted read returns rvalid with data one cycle later.

  state_t                state, stateNxt;
  logic [1:0]            row;
  logic [1:0]            puzzle;
  logic [ROWS*RW-1:0]    initCfg;
  logic                  lastGntB;
  logic                  acceptLoad;
  logic [RW-1:0]         protMask;
  logic [RW-1:0]         initRow;
  logic [RW-1:0]         protWdat;

  assign stateDbg = state;
  assign aRdat    = RamDat;
  assign bRdat    = RamDat;

  // Protected nibbles are forced back to the digits loaded from ROM.
  always_comb begin
    protMask = '0;
    for (int i = 0; i < NIB; i++) begin
      protMask[i*4 +: 4] = {4{wpMask[int'(aAddr)*NIB + i]}};
    end
  end

  assign initRow  = initCfg[int'(aAddr)*RW +: RW];
  assign protWdat = (aWdat & ~protMask) | (initRow & protMask);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= LOAD_RD;
      row      <= '0;
      puzzle   <= '0;
      wpMask   <= '0;
      initCfg  <= '0;
      lastGntB <= 1'b1;
      aRvalid  <= 1'b0;
      bRvalid  <= 1'b0;
      loadDone <= 1'b0;
    end else begin
      state    <= stateNxt;
      aRvalid  <= aGnt & ~aWe;
      bRvalid  <= bGnt;
      loadDone <= (state == LOAD_WR) && (row == LAST_ROW);
      if (state == LOAD_WR) begin
        wpMask[int'(row)*NIB +: NIB] <= RomDat[19:16];
        initCfg[int'(row)*RW +: RW]  <= RomDat[15:0];
        row                          <= (row == LAST_ROW) ? 2'd0 : row + 2'd1;
      end
      if (acceptLoad) puzzle <= puzzleSel;
      if (aGnt) lastGntB <= 1'b0;
      else if (bGnt) lastGntB <= 1'b1;
    end
  end

  always_comb begin
    stateNxt    = state;
    loadBusy    = 1'b0;
    aGnt        = 1'b0;
    bGnt        = 1'b0;
    acceptLoad  = 1'b0;
    RomAddr     = {puzzle, row};
    RamAddr     = '0;
    RamWriteBit = 1'b0;
    RamWdat     = '0;
    case (state)
      LOAD_RD: begin
        loadBusy = 1'b1;
        RamAddr  = row;
        stateNxt = LOAD_WR;
      end
      LOAD_WR: begin
        loadBusy    = 1'b1;
        RamAddr     = row;
        RamWriteBit = 1'b1;
        RamWdat     = RomDat[15:0];
        stateNxt    = (row == LAST_ROW) ? SERVE : LOAD_RD;
      end
      SERVE: begin
        if (loadReq) begin
          acceptLoad = 1'b1;
          stateNxt   = LOAD_RD;
        end else begin
          // With both requesting, the side not granted last time wins.
          aGnt = aReq & (~bReq | lastGntB);
          bGnt = bReq & (~aReq | ~lastGntB);
          if (aGnt) begin
            RamAddr     = aAddr;
            RamWriteBit = aWe;
            if (aWe) RamWdat = protWdat;
          end else if (bGnt) begin
            RamAddr = bAddr;
          end
        end
      end
      default: stateNxt = LOAD_RD;
    endcase
  end

endmodule
